// File: rtl/mem_port_if.sv
// mem_port_if
//   Bundles the requester-side request bus and the shared response bus of
//   mem_port_arbiter.
//
//   Handshake: a requester raises req_valid[i] with req_we/req_addr/req_wdata
//   and holds all of them stable until it sees req_ready[i]. The transfer
//   happens on the rising edge where req_valid[i] & req_ready[i] are both high.
//   Dropping req_valid[i] before that edge withdraws the request. Responses
//   are a single-cycle rsp_valid pulse with no backpressure.
//
//   Signals:
//     req_valid  [NUM_REQ]         per-requester request valid
//     req_ready  [NUM_REQ]         per-requester accept (one-hot or zero)
//     req_we     [NUM_REQ]         1 = write, 0 = read
//     req_addr   [NUM_REQ*ADDR_W]  packed word addresses, slice i*ADDR_W
//     req_wdata  [NUM_REQ*DATA_W]  packed write data, slice i*DATA_W
//     rsp_valid                    response pulse
//     rsp_id     [ID_W]            requester index of the response
//     rsp_rdata  [DATA_W]          read data (0 for writes and errors)
//     rsp_err                      address out of range
//     txn_count  [32]              saturating count of accepted transactions
//
//   Modports: master = requester side, slave = arbiter side.
interface mem_port_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 64
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_err;
   logic [31:0]               txn_count;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, txn_count
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, txn_count
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter in front of a single-port DEPTH x DATA_W scratch
//   memory. At most one request is accepted per cycle; its response is
//   registered and appears exactly one cycle after the accept edge.
//
//   Ports:
//     clk   in   sole clock, rising edge
//     rst   in   asynchronous, active-high reset
//     bus   slave modport of mem_port_if (request bus + response bus)
//
//   Handshake: req_ready[g] is asserted combinationally for the single
//   granted requester g; the transaction is accepted on the edge where
//   req_valid[g] & req_ready[g]. Requests must be held stable until then.
module mem_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DEPTH   = 1024,
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 64
) (
   input  logic       clk,
   input  logic       rst,
   mem_port_if.slave  bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int IDX_W = $clog2(DEPTH);

   // (p + k) mod NUM_REQ for 0 <= k < NUM_REQ; works for non power-of-two
   // requester counts.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p,
                                                input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
   logic [31:0]       txn_count_q, txn_count_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
   logic              rsp_err_q,   rsp_err_d;
   // rd_sel_q marks that rd_word_q carries a valid read result; rd_word_q
   // itself is the memory output register and is deliberately not reset.
   logic              rd_sel_q,    rd_sel_d;
   logic [DATA_W-1:0] rd_word_q;

   logic [DATA_W-1:0] mem [DEPTH];

   // ------------------------------------------------------------------
   // Grant selection: first valid requester at or after rr_ptr_q.
   // ------------------------------------------------------------------
   logic            gnt_found;
   logic [ID_W-1:0] gnt_idx;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!gnt_found && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
            gnt_found = 1'b1;
            gnt_idx   = wrap_add(rr_ptr_q, k);
         end
      end
   end

   // Nothing is granted while reset is high, so no accept (and therefore
   // no memory write) can happen on an edge where rst is asserted.
   logic accept;
   assign accept        = gnt_found & ~rst;
   assign bus.req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;

   // ------------------------------------------------------------------
   // Selected request fields and range check
   // ------------------------------------------------------------------
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              in_range;
   logic [IDX_W-1:0]  mem_idx;
   logic              wr_en;
   logic              rd_en;

   assign sel_we    = bus.req_we[gnt_idx];
   assign sel_addr  = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign sel_wdata = bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];

   // DEPTH is a power of two, so "a < DEPTH" is exactly "upper bits zero".
   assign in_range  = (sel_addr[ADDR_W-1:IDX_W] == '0);
   assign mem_idx   = sel_addr[IDX_W-1:0];

   assign wr_en     = accept &  sel_we & in_range;
   assign rd_en     = accept & ~sel_we & in_range;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      txn_count_d = txn_count_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = '0;
      rsp_err_d   = 1'b0;
      rd_sel_d    = 1'b0;

      if (accept) begin
         rr_ptr_d    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
         txn_count_d = (txn_count_q == 32'hFFFF_FFFF) ? txn_count_q
                                                      : txn_count_q + 32'd1;
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_idx;
         rsp_err_d   = ~in_range;
         rd_sel_d    = rd_en;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         txn_count_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
         rd_sel_q    <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         txn_count_q <= txn_count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
         rd_sel_q    <= rd_sel_d;
      end
   end

   // Single-port array with registered read; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[mem_idx] <= sel_wdata;
      end
      if (rd_en) begin
         rd_word_q <= mem[mem_idx];
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rd_sel_q ? rd_word_q : '0;
   assign bus.txn_count = txn_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int NUM_REQ = 4;
   localparam int DEPTH   = 1024;
   localparam int DATA_W  = 64;
   localparam int ADDR_W  = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(
      .NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   logic [63:0] mem_m [int];        // only in-range words that were written
   int          ptr_m;
   logic [31:0] cnt_m;
   // expected response: {rdata_known, err, id[7:0], rdata[63:0]}
   logic [73:0] exp_q [$];
   int          last_grant;
   logic [NUM_REQ-1:0] obs_rdy;
   int          rsp_per_id [NUM_REQ];

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant();
      for (int k = 0; k < NUM_REQ; k++) begin
         int i;
         i = (ptr_m + k) % NUM_REQ;
         if (bus.req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_accept(input int g);
      logic [63:0] a;
      logic [63:0] d;
      logic        we;
      logic        ok;
      logic        known;
      logic [63:0] rd;
      a  = bus.req_addr[g*ADDR_W +: ADDR_W];
      d  = bus.req_wdata[g*DATA_W +: DATA_W];
      we = bus.req_we[g];
      ok = (a < 64'(DEPTH));
      known = 1'b1;
      rd    = 64'd0;
      if (ok && we) begin
         mem_m[int'(a)] = d;
      end else if (ok && !we) begin
         if (mem_m.exists(int'(a))) rd = mem_m[int'(a)];
         else known = 1'b0;
      end
      exp_q.push_back({known, ~ok, 8'(g), rd});
      ptr_m = (g + 1) % NUM_REQ;
      if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
   endtask

   task automatic model_reset();
      ptr_m = 0;
      cnt_m = '0;
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic v, input logic we,
                          input logic [63:0] a, input logic [63:0] d);
      bus.req_valid[i]                  = v;
      bus.req_we[i]                     = we;
      bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
      bus.req_wdata[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic clear_reqs();
      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   // One clock: called at a negedge with inputs already driven; returns at
   // the next negedge after checking grant, response and counter.
   task automatic cycle();
      int g;
      logic [NUM_REQ-1:0] exp_rdy;
      logic [73:0] e;
      #1;
      g = model_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      obs_rdy = bus.req_ready;
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      last_grant = g;
      @(posedge clk);
      if (g >= 0) model_accept(g);
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
         check("rsp_id",    64'(bus.rsp_id),    64'(e[71:64]));
         check("rsp_err",   64'(bus.rsp_err),   64'(e[72]));
         if (e[73]) check("rsp_rdata", bus.rsp_rdata, e[63:0]);
         rsp_per_id[bus.rsp_id]++;
      end else begin
         check("rsp_idle", 64'(bus.rsp_valid), 64'd0);
      end
      check("txn_count", 64'(bus.txn_count), 64'(cnt_m));
   endtask

   task automatic rand_req(input int i);
      logic [63:0] a;
      logic [63:0] d;
      if ($urandom_range(0, 7) == 0)
         a = ($urandom_range(0, 1) == 0) ? 64'(DEPTH + $urandom_range(0, 99))
                                         : {32'($urandom_range(1, 255)), 32'd0};
      else
         a = 64'($urandom_range(0, 15));
      d = {32'($urandom), 32'($urandom)};
      set_req(i, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), a, d);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      clear_reqs();
      model_reset();
      for (int i = 0; i < NUM_REQ; i++) rsp_per_id[i] = 0;

      // Reset values, with requests pending during reset.
      bus.req_valid = '1;
      #3;
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
      check("rst_rsp_rdata", bus.rsp_rdata,      64'd0);
      check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
      check("rst_txn",       64'(bus.txn_count), 64'd0);
      check("rst_ready",     64'(bus.req_ready), 64'd0);
      repeat (2) @(negedge clk);
      clear_reqs();
      rst = 1'b0;

      // Single requester: write then read back-to-back.
      set_req(2, 1'b1, 1'b1, 64'h10, 64'h10);
      cycle();
      check("single_wr_gnt", 64'(obs_rdy), 64'b0100);
      set_req(2, 1'b1, 1'b0, 64'h10, 64'h0);
      cycle();
      check("single_rd_gnt", 64'(obs_rdy), 64'b0100);
      check("single_rd_id",    64'(bus.rsp_id),  64'd2);
      check("single_rd_rdata", bus.rsp_rdata,    64'h10);
      check("single_rd_err",   64'(bus.rsp_err), 64'd0);
      clear_reqs();
      cycle();

      // Out of range.
      set_req(0, 1'b1, 1'b1, 64'h0, 64'h1234);
      cycle();
      set_req(0, 1'b1, 1'b1, 64'd1024, 64'hDEAD);
      cycle();
      check("oor_err",   64'(bus.rsp_err), 64'd1);
      check("oor_rdata", bus.rsp_rdata,    64'd0);
      set_req(0, 1'b1, 1'b1, 64'h0000_0100_0000_0000, 64'hBEEF);
      cycle();
      check("oor_hi_err", 64'(bus.rsp_err), 64'd1);
      set_req(0, 1'b1, 1'b0, 64'h0, 64'h0);
      cycle();
      check("oor_addr0_intact", bus.rsp_rdata, 64'h1234);

      // Asynchronous reset mid-cycle while requester 0 reads.
      set_req(0, 1'b1, 1'b0, 64'h10, 64'h0);
      cycle();
      check("pre_arst_valid", 64'(bus.rsp_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("arst_ready",     64'(bus.req_ready), 64'd0);
      check("arst_txn",       64'(bus.txn_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, 1'b1, 1'b0, 64'(i), 64'h0);
      cycle();
      check("arst_first_gnt", 64'(obs_rdy), 64'b0001);

      // Fairness from reset: all four valid for 8 cycles.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < NUM_REQ; i++) rsp_per_id[i] = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("fair_order", 64'(obs_rdy), 64'(1) << (k % NUM_REQ));
      end
      check("fair_txn", 64'(bus.txn_count), 64'd8);
      for (int i = 0; i < NUM_REQ; i++)
         check("fair_rsp_per_id", 64'(rsp_per_id[i]), 64'd2);
      clear_reqs();

      // Pointer skip: move pointer to 2, then only 1 and 3 valid.
      set_req(1, 1'b1, 1'b1, 64'h20, 64'h5555);
      cycle();
      set_req(1, 1'b1, 1'b0, 64'h20, 64'h0);
      set_req(3, 1'b1, 1'b0, 64'h21, 64'h0);
      cycle();
      check("skip_g0", 64'(obs_rdy), 64'b1000);
      cycle();
      check("skip_g1", 64'(obs_rdy), 64'b0010);
      cycle();
      check("skip_g2", 64'(obs_rdy), 64'b1000);
      clear_reqs();
      cycle();

      // Randomized traffic; waiting requesters hold their request.
      for (int i = 0; i < NUM_REQ; i++) rand_req(i);
      for (int n = 0; n < 400; n++) begin
         cycle();
         for (int i = 0; i < NUM_REQ; i++)
            if (!bus.req_valid[i] || i == last_grant) rand_req(i);
      end
      clear_reqs();
      cycle();

      // Pattern fill through requester 1, then spot reads.
      for (int a = 0; a < DEPTH; a++) begin
         set_req(1, 1'b1, 1'b1, 64'(a), 64'(a));
         cycle();
      end
      set_req(1, 1'b1, 1'b0, 64'd0, 64'd0);
      cycle();
      check("pat_rd_0", bus.rsp_rdata, 64'd0);
      set_req(1, 1'b1, 1'b0, 64'd511, 64'd0);
      cycle();
      check("pat_rd_511", bus.rsp_rdata, 64'd511);
      set_req(1, 1'b1, 1'b0, 64'd1023, 64'd0);
      cycle();
      check("pat_rd_1023", bus.rsp_rdata, 64'd1023);
      clear_reqs();
      cycle();

      // Counter saturation.
      force dut.txn_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.txn_count_q;
      cnt_m = 32'hFFFF_FFFE;
      check("sat_preload", 64'(bus.txn_count), 64'hFFFF_FFFE);
      set_req(3, 1'b1, 1'b0, 64'd5, 64'd0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) cycle();
      check("sat_hold", 64'(bus.txn_count), 64'hFFFF_FFFF);
      clear_reqs();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
